// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range and streams each (address, data) pair out.
// Output handshake: a word transfers at a posedge where OutValid && OutReady; OutAddr/OutData hold until then.
module regfile_dump_reader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutAddr,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   WordCount,
  output logic [1:0]        StateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;

  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] lastReg;
  logic [ADDR_W-1:0] curInc;
  logic              atLast;
  logic              accept;
  logic              capture;
  logic              wordTaken;

  // Address arithmetic wraps modulo NUM_REGS, which need not be a power of two.
  assign curInc = (cur == ADDR_W'(NUM_REGS - 1)) ? '0 : cur + 1'b1;
  assign atLast = (cur == lastReg);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    capture   = 1'b0;
    wordTaken = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept    = 1'b1;
          stateNext = READ;
        end
      end
      READ: begin
        capture   = 1'b1;
        stateNext = SEND;
      end
      SEND: begin
        if (OutReady) begin
          wordTaken = 1'b1;
          stateNext = atLast ? DONE : READ;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cur       <= '0;
      lastReg   <= '0;
      OutAddr   <= '0;
      OutData   <= '0;
      WordCount <= '0;
    end else begin
      if (accept) begin
        cur       <= FirstReg;
        lastReg   <= LastReg;
        WordCount <= '0;
      end
      if (capture) begin
        OutData <= RdData;
        OutAddr <= cur;
      end
      // cur stays on the last register once the range is exhausted.
      if (wordTaken) begin
        WordCount <= WordCount + 1'b1;
        if (!atLast) begin
          cur <= curInc;
        end
      end
    end
  end

  assign RdAddr   = cur;
  assign OutValid = (state == SEND);
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign StateDbg = state;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: directed table of dump ranges, randomized dumps,
// and hand-written reset-during-send sequence, all checked against a range model.
module tb_regfile_dump_reader;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic [4:0]  FirstReg;
  logic [4:0]  LastReg;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  OutAddr;
  logic [31:0] OutData;
  logic        Busy;
  logic        Done;
  logic [5:0]  WordCount;
  logic [1:0]  StateDbg;

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .FirstReg(FirstReg), .LastReg(LastReg),
    .RdAddr(RdAddr), .RdData(RdData), .OutValid(OutValid), .OutReady(OutReady),
    .OutAddr(OutAddr), .OutData(OutData), .Busy(Busy), .Done(Done),
    .WordCount(WordCount), .StateDbg(StateDbg)
  );

  // Register file stand-in: r0 hardwired to zero.
  logic [31:0] rf [32];
  assign RdData = (RdAddr == 5'd0) ? 32'd0 : rf[RdAddr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nTests = 0;
  int nFail  = 0;
  logic [36:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the range First..Last inclusive, walking upward modulo 32.
  function automatic int rangeLen(input int first, input int last);
    return ((last - first + 32) % 32) + 1;
  endfunction

  task automatic buildExpected(input int first, input int last);
    int a;
    exp_q.delete();
    for (int j = 0; j < rangeLen(first, last); j++) begin
      a = (first + j) % 32;
      exp_q.push_back({5'(a), (a == 0) ? 32'd0 : rf[a]});
    end
  endtask

  task automatic runDump(input int first, input int last, input int stallWord, input int stallLen,
                         input bit midStart, input bit randReady, input int expCount);
    int k, lastAcc, stallCnt;
    bit doneSeen;
    logic [4:0]  hAddr;
    logic [31:0] hData;
    logic [36:0] e;
    k = 0; lastAcc = 0; stallCnt = 0; doneSeen = 0;
    hAddr = '0; hData = '0;
    buildExpected(first, last);
    @(negedge CLK);
    Start = 1'b1; FirstReg = 5'(first); LastReg = 5'(last); OutReady = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    FirstReg = 5'($urandom); LastReg = 5'($urandom);
    check("busy_after_start", Busy, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (midStart && cyc == 3) begin
        Start = 1'b1; FirstReg = 5'(first + 9); LastReg = 5'(first + 20);
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        doneSeen = 1;
        check("queue_empty_at_done", exp_q.size(), 0);
        check("wordcount_at_done", WordCount, expCount);
        check("busy_during_done", Busy, 1);
        break;
      end
      if (OutValid && k == stallWord && stallCnt < stallLen) begin
        OutReady = 1'b0;
        if (stallCnt == 0) begin
          hAddr = OutAddr; hData = OutData;
        end else begin
          check("stall_addr_held", OutAddr, hAddr);
          check("stall_data_held", OutData, hData);
        end
        stallCnt++;
      end else begin
        OutReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word_addr", OutAddr, e[36:32]);
          check("word_data", OutData, e[31:0]);
        end
        if (stallWord < 0 && !randReady && k > 0) check("word_spacing", cyc - lastAcc, 2);
        lastAcc = cyc;
        k++;
      end
      @(negedge CLK);
    end
    if (!doneSeen) check("done_timeout", 0, 1);
    Start = 1'b0;
    @(negedge CLK);
    check("done_one_pulse", Done, 0);
    check("busy_low_after_done", Busy, 0);
    check("wordcount_hold", WordCount, expCount);
  endtask

  typedef struct {
    int first;
    int last;
    int stallWord;
    int stallLen;
    bit midStart;
    int expCount;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int first, last;
    bit sawSend;
    Reset = 1'b1; Start = 1'b0; FirstReg = '0; LastReg = '0; OutReady = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    #2;
    check("reset_busy", Busy, 0);
    check("reset_valid", OutValid, 0);
    check("reset_done", Done, 0);
    check("reset_wordcount", WordCount, 0);
    check("reset_rdaddr", RdAddr, 0);
    check("reset_state", StateDbg, 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    vecs[0] = '{first: 0,  last: 31, stallWord: -1, stallLen: 0, midStart: 0, expCount: 32};
    vecs[1] = '{first: 5,  last: 5,  stallWord: -1, stallLen: 0, midStart: 0, expCount: 1};
    vecs[2] = '{first: 30, last: 1,  stallWord: -1, stallLen: 0, midStart: 0, expCount: 4};
    vecs[3] = '{first: 2,  last: 4,  stallWord: 1,  stallLen: 7, midStart: 0, expCount: 3};
    vecs[4] = '{first: 10, last: 13, stallWord: -1, stallLen: 0, midStart: 1, expCount: 4};
    for (int v = 0; v < 5; v++) begin
      if (v == 1) rf[5] = 32'hDEADBEEF;
      runDump(vecs[v].first, vecs[v].last, vecs[v].stallWord, vecs[v].stallLen,
              vecs[v].midStart, 1'b0, vecs[v].expCount);
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      first = $urandom_range(0, 31);
      last  = $urandom_range(0, 31);
      runDump(first, last, -1, 0, 1'b0, 1'b1, rangeLen(first, last));
    end

    // Asynchronous reset while a word is waiting in SEND.
    @(negedge CLK);
    Start = 1'b1; FirstReg = 5'd10; LastReg = 5'd20; OutReady = 1'b0;
    @(negedge CLK);
    Start = 1'b0;
    sawSend = 0;
    for (int c = 0; c < 10 && !sawSend; c++) begin
      @(negedge CLK);
      sawSend = OutValid;
    end
    check("reach_send", sawSend, 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_valid", OutValid, 0);
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_addr", OutAddr, 0);
    check("arst_data", OutData, 0);
    check("arst_wordcount", WordCount, 0);
    check("arst_rdaddr", RdAddr, 0);
    check("arst_state", StateDbg, 0);
    #1 Reset = 1'b0;
    @(negedge CLK);
    check("post_reset_idle", Busy, 0);
    runDump(7, 8, -1, 0, 1'b0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
